result_drain: RTL and testbench
===============================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 The block SHALL expose parameter NUM_PE, default 8: number of PE results captured per row.
REQ-002 The block SHALL expose parameter ACCUM_WIDTH, default 32: width of each signed PE total.
REQ-003 The block SHALL expose parameter ROWS, default 8: rows per output matrix; row counter wraps here.
REQ-004 The block SHALL have ports: clk, in, 1, the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have ports: rst, in, 1, synchronous active-high reset.
REQ-006 The block SHALL have ports: cap_valid, in, 1, all PE totals valid this cycle; cap_ready, out, 1, block can capture.
REQ-007 The block SHALL have ports: totals, in, NUM_PE x ACCUM_WIDTH signed, PE dot products; pe_err, in, NUM_PE, per-PE error flags.
REQ-008 The block SHALL have ports: out_valid, out, 1; out_ready, in, 1; out_data, out, ACCUM_WIDTH signed; out_err, out, 1, pe_err of this element.
REQ-009 The block SHALL have ports: out_row, out, max(1,clog2(ROWS)); out_col, out, max(1,clog2(NUM_PE)); out_last_col, out, 1; out_last_row, out, 1.
REQ-010 The block SHALL have ports: overrun, out, 1, sticky lost-capture flag; clr_overrun, in, 1, clears overrun.
REQ-011 Reset and clocking SHALL be: one clock; reset is synchronous and active-high.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and DRAIN; cap_ready = (state==IDLE); out_valid = (state==DRAIN).
REQ-013 In IDLE with cap_valid=1, the block SHALL latch totals and pe_err into a shadow buffer, set col=0, and enter DRAIN on the next edge.
REQ-014 Latency SHALL be one cycle: capture at edge k gives out_valid=1 with col 0 data from cycle k+1.
REQ-015 In DRAIN, out_data/out_err SHALL equal shadow entry [col]; a beat transfers on any cycle with out_valid & out_ready.
REQ-016 While out_valid=1 and out_ready=0, out_data, out_err, out_row, out_col and the last flags SHALL hold stable.
REQ-017 On a transfer with col<NUM_PE-1, col SHALL increment by 1; the state stays DRAIN.
REQ-018 On a transfer with col==NUM_PE-1, the state SHALL return to IDLE, and row SHALL increment, wrapping from ROWS-1 to 0.
REQ-019 out_last_col SHALL be (col==NUM_PE-1); out_last_row SHALL be (row==ROWS-1); both are qualified by out_valid.
REQ-020 cap_valid in DRAIN SHALL be ignored for data (shadow buffer unchanged) and SHALL set overrun on the next edge.
REQ-021 overrun SHALL stay set until clr_overrun=1; if set and clear occur in the same cycle, set SHALL win.
REQ-022 With NUM_PE=1, each capture SHALL produce exactly one beat, with out_last_col=1.
REQ-023 Minimum capture period SHALL be NUM_PE+1 cycles with out_ready held high.
REQ-024 Data SHALL pass unmodified: no truncation or sign change of totals.

Reset
REQ-025 While rst=1 at an edge: state=IDLE, col=0, row=0, overrun=0, and the shadow buffer and its error bits SHALL clear to 0.
REQ-026 After reset, out_valid=0, out_data=0, out_err=0, out_row=0, out_col=0, out_last_col=0, out_last_row=0 and cap_ready=1.
REQ-027 cap_valid SHALL be ignored in any cycle with rst=1.
REQ-028 Reset asserted during DRAIN SHALL abandon the remaining beats; no beat of that row SHALL appear afterwards.

Verification (NUM_PE=4, ROWS=2)
REQ-029 Basic: capture totals {5,-3,7,100}, out_ready=1 -> beats 5,-3,7,100 on 4 consecutive cycles starting 1 cycle after capture; out_col 0..3; out_last_col only on 100; out_row=0; then cap_ready=1.
REQ-030 Backpressure: toggle out_ready 1,0,0,1,... -> every value is held across stalls; no beat is duplicated or dropped; order is preserved.
REQ-031 Row wrap: 3 captures back-to-back -> out_row sequence 0,1,0; out_last_row=1 on all beats of row 1 only.
REQ-032 Overrun: pulse cap_valid with new totals during DRAIN -> overrun=1 next cycle; output values unchanged; clr_overrun together with a second overrun event leaves overrun=1; clr_overrun alone clears it.
REQ-033 Error pass-through: pe_err=4'b0100 at capture -> out_err=1 only on the col 2 beat.
REQ-034 Mid-drain reset: rst=1 after beat col 1 -> next cycle out_valid=0, row=0, cap_ready=1; the next capture starts at col 0.

Source files
------------

// File: rtl/result_drain.sv
// Captures one row of signed PE totals into a shadow buffer and streams it out one column per beat.
// A capture that arrives while a row is still draining is dropped and recorded in the sticky overrun flag.
module result_drain #(
    parameter int NUM_PE      = 8,
    parameter int ACCUM_WIDTH = 32,
    parameter int ROWS        = 8,
    localparam int CW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cap_valid,
    output logic                                        cap_ready,
    input  logic signed [NUM_PE-1:0][ACCUM_WIDTH-1:0]   totals,
    input  logic        [NUM_PE-1:0]                    pe_err,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic signed [ACCUM_WIDTH-1:0]               out_data,
    output logic                                        out_err,
    output logic        [RW-1:0]                        out_row,
    output logic        [CW-1:0]                        out_col,
    output logic                                        out_last_col,
    output logic                                        out_last_row,
    output logic                                        overrun,
    input  logic                                        clr_overrun,
    output logic                                        state_dbg
);

    // Handshakes: a capture happens when cap_valid & cap_ready at a rising edge;
    // an output beat transfers when out_valid & out_ready at a rising edge.
    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    localparam logic [CW-1:0] LAST_COL = CW'(NUM_PE - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    state_t                             state;
    state_t                             state_next;
    logic                               capture;
    logic                               xfer;
    logic [CW-1:0]                      col;
    logic [RW-1:0]                      row;
    logic [NUM_PE-1:0][ACCUM_WIDTH-1:0] shadow;
    logic [NUM_PE-1:0]                  shadow_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            overrun    <= 1'b0;
            shadow     <= '0;
            shadow_err <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                shadow     <= totals;
                shadow_err <= pe_err;
                col        <= '0;
            end else if (xfer) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // A lost capture outranks a simultaneous clear.
            if (state == DRAIN && cap_valid) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (cap_valid) begin
                    capture    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    xfer = 1'b1;
                    if (col == LAST_COL) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cap_ready    = (state == IDLE);
    assign out_valid    = (state == DRAIN);
    assign out_data     = out_valid ? shadow[col] : '0;
    assign out_err      = out_valid & shadow_err[col];
    assign out_row      = row;
    assign out_col      = col;
    assign out_last_col = out_valid & (col == LAST_COL);
    assign out_last_row = out_valid & (row == LAST_ROW);
    assign state_dbg    = (state == DRAIN);

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain with NUM_PE=4, ROWS=2: directed scenarios followed by random traffic,
// each output beat compared against a queue of expected beats built from the captured rows.
module tb_result_drain;

    localparam int NUM_PE = 4;
    localparam int AW     = 32;
    localparam int ROWS   = 2;
    localparam int BW     = AW + 1 + 1 + 2 + 1 + 1;

    logic                          clk;
    logic                          rst;
    logic                          cap_valid;
    logic                          cap_ready;
    logic signed [NUM_PE-1:0][AW-1:0] totals;
    logic        [NUM_PE-1:0]      pe_err;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [AW-1:0]          out_data;
    logic                          out_err;
    logic        [0:0]             out_row;
    logic        [1:0]             out_col;
    logic                          out_last_col;
    logic                          out_last_row;
    logic                          overrun;
    logic                          clr_overrun;
    logic                          state_dbg;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: pending beats {data, err, row, col, last_col, last_row}.
    logic [BW-1:0] exp_q[$];
    int            cap_count = 0;
    logic          exp_ovr   = 1'b0;

    result_drain #(.NUM_PE(NUM_PE), .ACCUM_WIDTH(AW), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .totals(totals), .pe_err(pe_err), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .out_row(out_row), .out_col(out_col),
        .out_last_col(out_last_col), .out_last_row(out_last_row), .overrun(overrun),
        .clr_overrun(clr_overrun), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_row();
        int r;
        r = cap_count % ROWS;
        for (int c = 0; c < NUM_PE; c++) begin
            exp_q.push_back({totals[c], pe_err[c], 1'(r), 2'(c),
                             1'(c == NUM_PE - 1), 1'(r == ROWS - 1)});
        end
        cap_count++;
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, cross the edge.
    task automatic tick();
        logic          busy;
        logic [BW-1:0] obs;
        #4;
        busy = (exp_q.size() != 0);
        check("out_valid", 64'(out_valid), 64'(busy));
        check("cap_ready", 64'(cap_ready), 64'(!busy));
        check("overrun", 64'(overrun), 64'(exp_ovr));
        if (busy) begin
            obs = {out_data, out_err, out_row, out_col, out_last_col, out_last_row};
            check("beat", 64'(obs), 64'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
        end else begin
            check("idle_row", 64'(out_row), 64'(cap_count % ROWS));
        end
        if (rst) begin
            exp_q.delete();
            cap_count = 0;
            exp_ovr   = 1'b0;
        end else begin
            if (cap_valid && busy) exp_ovr = 1'b1;
            else if (clr_overrun) exp_ovr = 1'b0;
            if (cap_valid && !busy) push_row();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [AW-1:0] t0, t1, t2, t3, input logic [3:0] err);
        totals[0] = t0; totals[1] = t1; totals[2] = t2; totals[3] = t3;
        pe_err    = err;
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        #4;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_out_row", 64'(out_row), 64'd0);
        check("rst_out_col", 64'(out_col), 64'd0);
        check("rst_last_col", 64'(out_last_col), 64'd0);
        check("rst_last_row", 64'(out_last_row), 64'd0);
        check("rst_cap_ready", 64'(cap_ready), 64'd1);
        check("rst_overrun", 64'(overrun), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int caps;
        rst = 1'b1; cap_valid = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
        totals = '0; pe_err = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs();

        // Basic row drain with out_ready held high.
        out_ready = 1'b1;
        capture(32'd5, -32'sd3, 32'd7, 32'd100, 4'b0000);
        repeat (5) tick();

        // Backpressure pattern 1,0,0,1 repeating.
        capture($urandom, $urandom, $urandom, $urandom, 4'(($urandom_range(0, 15))));
        for (int i = 0; i < 14; i++) begin
            out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            tick();
        end
        out_ready = 1'b1;
        repeat (2) tick();

        // Row wrap: three back-to-back captures after a fresh reset.
        rst = 1'b1; tick(); rst = 1'b0;
        caps = 0;
        for (int i = 0; i < 16; i++) begin
            cap_valid = (exp_q.size() == 0) && (caps < 3);
            if (cap_valid) begin
                caps++;
                for (int c = 0; c < NUM_PE; c++) totals[c] = $urandom;
            end
            tick();
        end
        cap_valid = 1'b0;

        // Overrun: lost capture, set-beats-clear, then clear alone.
        out_ready = 1'b0;
        capture(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 4'b0000);
        capture($urandom, $urandom, $urandom, $urandom, 4'b1111);
        tick();
        cap_valid = 1'b1; clr_overrun = 1'b1; tick();
        cap_valid = 1'b0; clr_overrun = 1'b0; tick();
        clr_overrun = 1'b1; tick();
        clr_overrun = 1'b0; tick();
        out_ready = 1'b1;
        repeat (5) tick();

        // Error pass-through on column 2 only.
        capture(32'd1, 32'd2, 32'd3, 32'd4, 4'b0100);
        repeat (5) tick();

        // Reset after the col 1 beat abandons the rest of the row.
        capture(32'd10, 32'd11, 32'd12, 32'd13, 4'b0000);
        repeat (2) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_outputs();
        capture(-32'sd1, 32'h8000_0000, 32'h7fff_ffff, 32'd0, 4'b1001);
        repeat (5) tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 60) == 0);
            cap_valid   = ($urandom_range(0, 3) == 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            clr_overrun = ($urandom_range(0, 7) == 0);
            pe_err      = 4'($urandom_range(0, 15));
            for (int c = 0; c < NUM_PE; c++) totals[c] = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
